// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle sequencer: FSM state encoding,
// opcode and condition-code values, and instruction-register field positions.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMem       = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6
  } state_e;

  localparam logic [3:0] OP_LDR = 4'hD;
  localparam logic [3:0] OP_STR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned IR_COND_LSB = 28;
  localparam int unsigned IR_OP_LSB   = 24;
  localparam int unsigned IR_S_BIT    = 23;

  // Bit positions inside the NZCV flags nibble.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic [3:0] ir_cond(input logic [31:0] ir);
    return ir[IR_COND_LSB +: 4];
  endfunction

  function automatic logic [3:0] ir_opcode(input logic [31:0] ir);
    return ir[IR_OP_LSB +: 4];
  endfunction

  function automatic logic ir_s_bit(input logic [31:0] ir);
    return ir[IR_S_BIT];
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM-style condition evaluator: decides whether an instruction's cond field
// passes against the current NZCV flags. Purely combinational.
module cond_check
  import cpu_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: owns PC and IR and steps each instruction through
// fetch/decode/execute/mem/writeback. Optional SEQ_SINGLE_STEP_EN parks in IDLE
// after every instruction and adds a `step` input.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  input  logic [3:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic            mem_req,
  output logic            mem_we,
  output logic            sel_add_bus,
  output logic            sel_ldr_bus,
  output logic            reg_we,
  output logic            flag_we,
  output logic            halted,
  output logic            err,
  output logic [2:0]      state
);

  localparam logic [3:0] TimeoutCnt = 4'(ACK_TIMEOUT);

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_e DoneState = StIdle;
  logic go;
  assign go = run | step;
`else
  localparam state_e DoneState = StFetch;
  logic go;
  assign go = run;
`endif

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [3:0]      wait_q, wait_d, wait_inc;
  logic            err_q, err_d;

  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic sel_add_q, sel_add_d;
  logic sel_ldr_q, sel_ldr_d;
  logic reg_we_q, reg_we_d;
  logic flag_we_q, flag_we_d;
  logic halted_q, halted_d;

  logic [3:0] cond_cur, op_cur, op_nxt;
  logic       is_ldr, is_str, cond_pass, s_nxt;

  assign cond_cur = ir_cond(ir_q);
  assign op_cur   = ir_opcode(ir_q);
  assign is_ldr   = (op_cur == OP_LDR);
  assign is_str   = (op_cur == OP_STR);
  assign wait_inc = wait_q + 4'd1;

  cond_check u_cond_check (
    .cond  (cond_cur),
    .flags (flags),
    .pass  (cond_pass)
  );

  // Next-state; the wait counter only survives a cycle spent waiting on ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = 4'd0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (go) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end else if (wait_inc == TimeoutCnt) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_inc;
        end
      end
      StDecode: begin
        if (!cond_pass) begin
          state_d = DoneState;
        end else if (op_cur == OP_HLT) begin
          state_d = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        state_d = (is_ldr || is_str) ? StMem : StWriteback;
      end
      StMem: begin
        if (mem_ack) begin
          state_d = is_ldr ? StWriteback : DoneState;
        end else if (wait_inc == TimeoutCnt) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_inc;
        end
      end
      StWriteback: begin
        state_d = DoneState;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes are registered from the upcoming state so every output is a flop.
  assign op_nxt = ir_opcode(ir_d);
  assign s_nxt  = ir_s_bit(ir_d);

  always_comb begin
    mem_req_d = (state_d == StFetch) || (state_d == StMem);
    mem_we_d  = (state_d == StMem) && (op_nxt == OP_STR);
    sel_add_d = (state_d == StMem);
    sel_ldr_d = (state_d == StWriteback) && (op_nxt == OP_LDR);
    reg_we_d  = (state_d == StWriteback);
    flag_we_d = (state_d == StWriteback) && s_nxt && (op_nxt != OP_LDR);
    halted_d  = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      wait_q    <= 4'd0;
      err_q     <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      sel_add_q <= 1'b0;
      sel_ldr_q <= 1'b0;
      reg_we_q  <= 1'b0;
      flag_we_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      sel_add_q <= sel_add_d;
      sel_ldr_q <= sel_ldr_d;
      reg_we_q  <= reg_we_d;
      flag_we_q <= flag_we_d;
      halted_q  <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign sel_add_bus = sel_add_q;
  assign sel_ldr_bus = sel_ldr_q;
  assign reg_we      = reg_we_q;
  assign flag_we     = flag_we_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a small RAM driver answers the handshake and a
// writeback scoreboard checks every register/flag strobe against queued expectations.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  flags;
  logic [7:0]  pc;
  logic [31:0] ir;
  logic        mem_req, mem_we, sel_add_bus, sel_ldr_bus;
  logic        reg_we, flag_we, halted, err;
  logic [2:0]  state;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  cpu_sequencer #(
    .PC_W        (8),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
`ifdef SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .flags       (flags),
    .pc          (pc),
    .ir          (ir),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .sel_add_bus (sel_add_bus),
    .sel_ldr_bus (sel_ldr_bus),
    .reg_we      (reg_we),
    .flag_we     (flag_we),
    .halted      (halted),
    .err         (err),
    .state       (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic ldr;
    logic fw;
  } wb_t;

  wb_t sb_q[$];
  wb_t sb_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wb(input logic ldr, input logic fw);
    sb_e.ldr = ldr;
    sb_e.fw  = fw;
    sb_q.push_back(sb_e);
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && (reg_we || flag_we)) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", {30'd0, reg_we, flag_we}, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("wb_reg_we", 32'(reg_we), 32'd1);
        check("wb_sel_ldr", 32'(sel_ldr_bus), 32'(sb_e.ldr));
        check("wb_flag_we", 32'(flag_we), 32'(sb_e.fw));
      end
    end
  end

  // Called with the DUT freshly in FETCH; runs until the next FETCH entry or HALT.
  task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait,
                           output int cycles, output int n_add, output int n_we,
                           output int wb_cyc);
    int         fw;
    int         mw;
    logic [2:0] prev;
    fw = 0;
    mw = 0;
    cycles = 0;
    n_add = 0;
    n_we = 0;
    wb_cyc = 0;
    for (int i = 0; i < 64; i++) begin
      cycles++;
      if (sel_add_bus) n_add++;
      if (mem_we) n_we++;
      if (reg_we) wb_cyc = cycles;
      mem_ack = 1'b0;
      if (state == StFetch) begin
        if (fw == fwait) begin
          mem_ack   = 1'b1;
          mem_rdata = instr;
        end
        fw++;
      end else if (state == StMem) begin
        if (mw == mwait) mem_ack = 1'b1;
        mw++;
      end
      prev = state;
      tick();
      if ((state == StFetch && prev != StFetch) || state == StHalt) break;
    end
    mem_ack = 1'b0;
  endtask

  logic [31:0] ct_instr [11] = '{32'h0000_0000, 32'h0000_0000, 32'h1000_0000, 32'h8000_0000,
                                 32'h9000_0000, 32'hA000_0000, 32'hB000_0000, 32'hC000_0000,
                                 32'hD000_0000, 32'hF000_0000, 32'h0F00_0000};
  logic [3:0]  ct_flags [11] = '{4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b1000,
                                 4'b1000, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
  logic        ct_pass  [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, na, nw, wc;
    logic [7:0] exp_pc;
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0; flags = 4'b0000;
    tick();
    tick();
    check("rst_state", state, StIdle);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_strobes", {mem_req, mem_we, sel_add_bus, sel_ldr_bus, reg_we, flag_we}, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);

    rst = 1'b0;
    tick();
    check("idle_hold", state, StIdle);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("run_fetch", state, StFetch);
    check("fetch_req", {mem_req, sel_add_bus, mem_we}, 3'b100);

    // ALU op, s=0
    push_wb(1'b0, 1'b0);
    run_instr(32'hE000_0000, 0, 0, cyc, na, nw, wc);
    check("alu_cycles", cyc, 4);
    check("alu_wb_cyc", wc, 4);
    check("alu_pc", pc, 1);
    check("alu_ir", ir, 32'hE000_0000);

    // ALU op, s=1
    push_wb(1'b0, 1'b1);
    run_instr(32'hE080_0000, 0, 0, cyc, na, nw, wc);
    check("alus_cycles", cyc, 4);
    check("alus_wb_cyc", wc, 4);
    check("alus_next_fetch", state, StFetch);
    check("alus_pc", pc, 2);

    // LDR with MEM ack delayed three cycles
    push_wb(1'b1, 1'b0);
    run_instr(32'hED00_0000, 0, 3, cyc, na, nw, wc);
    check("ldr_cycles", cyc, 8);
    check("ldr_sel_add", na, 4);
    check("ldr_wb_cyc", wc, 8);
    check("ldr_mem_we", nw, 0);
    check("ldr_pc", pc, 3);

    // STR: no writeback
    run_instr(32'hEE00_0000, 0, 0, cyc, na, nw, wc);
    check("str_cycles", cyc, 4);
    check("str_mem_we", nw, 1);
    check("str_sel_add", na, 1);
    check("str_pc", pc, 4);

    // Fetch ack delayed two cycles
    push_wb(1'b0, 1'b0);
    run_instr(32'hE000_0000, 2, 0, cyc, na, nw, wc);
    check("fwait_cycles", cyc, 6);
    check("fwait_wb_cyc", wc, 6);

    exp_pc = 8'd5;
    for (int i = 0; i < 11; i++) begin
      flags = ct_flags[i];
      if (ct_pass[i]) push_wb(1'b0, 1'b0);
      run_instr(ct_instr[i], 0, 0, cyc, na, nw, wc);
      exp_pc = exp_pc + 8'd1;
      check($sformatf("cond%0d_cycles", i), cyc, ct_pass[i] ? 4 : 2);
      check($sformatf("cond%0d_pc", i), pc, 32'(exp_pc));
      check($sformatf("cond%0d_halted", i), halted, 0);
    end
    flags = 4'b0000;

    // Walk PC up to all-ones with never-executing instructions, then wrap.
    for (int i = 0; i < 300 && exp_pc != 8'hFF; i++) begin
      run_instr(32'hF000_0000, 0, 0, cyc, na, nw, wc);
      exp_pc = exp_pc + 8'd1;
    end
    check("pc_ff", pc, 8'hFF);
    run_instr(32'hF000_0000, 0, 0, cyc, na, nw, wc);
    check("pc_wrap", pc, 8'h00);

    // HLT, then run pulses are ignored
    run_instr(32'hEF00_0000, 0, 0, cyc, na, nw, wc);
    check("hlt_cycles", cyc, 2);
    check("hlt_halted", halted, 1);
    check("hlt_state", state, StHalt);
    check("hlt_err", err, 0);
    run = 1'b1;
    tick();
    tick();
    tick();
    run = 1'b0;
    check("hlt_hold", {halted, state}, {1'b1, StHalt});
    check("hlt_no_req", mem_req, 0);
    check("hlt_pc", pc, 8'h01);

    // rst beats run
    rst = 1'b1; run = 1'b1;
    tick();
    check("rst_wins", {state, halted}, {StIdle, 1'b0});
    rst = 1'b0;
    tick();
    run = 1'b0;
    check("fetch_after_rst", state, StFetch);

    // Fetch ack timeout
    run_instr(32'hE000_0000, 100, 0, cyc, na, nw, wc);
    check("fto_cycles", cyc, 15);
    check("fto_err", err, 1);
    check("fto_halted", halted, 1);
    check("fto_req", mem_req, 0);
    check("fto_pc", pc, 0);
    rst = 1'b1;
    tick();
    check("fto_rst", {state, err, halted, mem_req}, {StIdle, 3'b000});
    check("fto_rst_pc", pc, 0);

    // MEM ack timeout on LDR
    rst = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    run_instr(32'hED00_0000, 0, 100, cyc, na, nw, wc);
    check("mto_cycles", cyc, 18);
    check("mto_sel_add", na, 15);
    check("mto_err", {err, halted}, 2'b11);
    check("mto_pc", pc, 1);

    // Reset in the middle of a fetch handshake
    rst = 1'b1;
    tick();
    rst = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    push_wb(1'b0, 1'b0);
    run_instr(32'hE000_0000, 0, 0, cyc, na, nw, wc);
    check("mid_pre_pc", pc, 1);
    tick();
    tick();
    check("mid_waiting", {state, mem_req}, {StFetch, 1'b1});
    rst = 1'b1;
    tick();
    check("mid_req_drop", mem_req, 0);
    check("mid_pc", pc, 0);
    check("mid_state", state, StIdle);
    rst = 1'b0;
    tick();
    check("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
